// File: rtl/reel_stop_sequencer.sv
// -----------------------------------------------------------------------------
// reel_stop_sequencer
//
// Sequences one slot-machine spin. A START rising edge with credit available
// releases the three reel counters, the reels are then stopped one after the
// other on a fixed stagger, the three stopped digits are captured and the
// payout for the captured combination is reported.
//
// Optional feature (compile-time macro SKILL_STOP_EN):
//   defined   - a STOP_REQ rising edge ends the current SPIN/STAG1/STAG2 phase
//               in the cycle it is seen (one edge ends one phase).
//   undefined - STOP_REQ is ignored and every phase is purely timed.
//
// Ports:
//   i_clk                  system clock (single domain)
//   i_rst                  asynchronous active-high reset
//   i_start                spin request level; rising edge = request
//   i_credit_ok            credit counter is nonzero
//   i_stop_req             player stop button (SKILL_STOP_EN builds only)
//   i_reel1..i_reel3       current BCD digit of each reel
//   o_stop1..o_stop3       1 = reel frozen
//   o_debit                one-cycle pulse when a spin is accepted
//   o_busy                 high from SPIN through EVAL
//   o_done                 one-cycle pulse, o_payout valid
//   o_payout               award for the last spin
//   o_result               captured digits {reel1, reel2, reel3}
// -----------------------------------------------------------------------------
module reel_stop_sequencer #(
    parameter int SPIN_CYCLES    = 10000000,
    parameter int STAGGER_CYCLES = 5000000,
    parameter int CNT_W          = 24,
    parameter int PAYOUT_PAIR    = 2,
    parameter int PAYOUT_TRIPLE  = 10,
    parameter int PAYOUT_JACKPOT = 50
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_credit_ok,
    input  logic        i_stop_req,
    input  logic [3:0]  i_reel1,
    input  logic [3:0]  i_reel2,
    input  logic [3:0]  i_reel3,
    output logic        o_stop1,
    output logic        o_stop2,
    output logic        o_stop3,
    output logic        o_debit,
    output logic        o_busy,
    output logic        o_done,
    output logic [6:0]  o_payout,
    output logic [11:0] o_result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPIN  = 3'd1,
        S_STAG1 = 3'd2,
        S_STAG2 = 3'd3,
        S_EVAL  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        r_stop;          // {stop1, stop2, stop3}
    logic [2:0]        w_stop_nxt;
    logic              r_debit;
    logic              w_debit_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic [6:0]        r_payout;
    logic [6:0]        w_payout_nxt;
    logic [11:0]       r_result;
    logic [11:0]       w_result_nxt;

    // Previous START level; resets to 1 so a START held through reset release
    // does not look like a fresh request.
    logic              r_start_d;
    logic              w_start_rise;
    logic              w_skip;          // player-forced end of current phase
    logic              w_spin_tc;
    logic              w_stag_tc;

    assign w_start_rise = i_start & ~r_start_d;

`ifdef SKILL_STOP_EN
    logic r_stop_req_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stop_req_d <= 1'b1;
        end else begin
            r_stop_req_d <= i_stop_req;
        end
    end

    assign w_skip = i_stop_req & ~r_stop_req_d;
`else
    logic w_unused_stop_req;

    assign w_unused_stop_req = i_stop_req;
    assign w_skip            = 1'b0;
`endif

    assign w_spin_tc = (r_cnt == CNT_W'(SPIN_CYCLES - 1))    | w_skip;
    assign w_stag_tc = (r_cnt == CNT_W'(STAGGER_CYCLES - 1)) | w_skip;

    // Award for three captured digits. Only BCD digits (0..9) can take part
    // in a match, so an invalid pattern such as A-A-A pays nothing.
    function automatic logic [6:0] payout_calc(input logic [3:0] d1,
                                               input logic [3:0] d2,
                                               input logic [3:0] d3);
        logic v1, v2, v3;
        logic m12, m13, m23;
        v1  = (d1 <= 4'd9);
        v2  = (d2 <= 4'd9);
        v3  = (d3 <= 4'd9);
        m12 = v1 & v2 & (d1 == d2);
        m13 = v1 & v3 & (d1 == d3);
        m23 = v2 & v3 & (d2 == d3);
        if ((d1 == 4'd7) && (d2 == 4'd7) && (d3 == 4'd7)) begin
            payout_calc = 7'(PAYOUT_JACKPOT);
        end else if (m12 && m23) begin
            payout_calc = 7'(PAYOUT_TRIPLE);
        end else if (m12 || m13 || m23) begin
            payout_calc = 7'(PAYOUT_PAIR);
        end else begin
            payout_calc = 7'd0;
        end
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_stop    <= 3'b111;
            r_debit   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_payout  <= 7'd0;
            r_result  <= 12'd0;
            r_start_d <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stop    <= w_stop_nxt;
            r_debit   <= w_debit_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_payout  <= w_payout_nxt;
            r_result  <= w_result_nxt;
            r_start_d <= i_start;   // tracks even while busy, so no retrigger
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stop_nxt   = r_stop;
        w_debit_nxt  = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_payout_nxt = r_payout;
        w_result_nxt = r_result;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start_rise && i_credit_ok) begin
                    w_state_nxt  = S_SPIN;
                    w_stop_nxt   = 3'b000;
                    w_debit_nxt  = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_payout_nxt = 7'd0;
                end
            end
            S_SPIN: begin
                if (w_spin_tc) begin
                    w_result_nxt[11:8] = i_reel1;
                    w_stop_nxt[2]      = 1'b1;
                    w_cnt_nxt          = '0;
                    w_state_nxt        = S_STAG1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STAG1: begin
                if (w_stag_tc) begin
                    w_result_nxt[7:4] = i_reel2;
                    w_stop_nxt[1]     = 1'b1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = S_STAG2;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STAG2: begin
                if (w_stag_tc) begin
                    w_result_nxt[3:0] = i_reel3;
                    w_stop_nxt[0]     = 1'b1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = S_EVAL;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_EVAL: begin
                // r_result is complete here: reel 3 was captured on entry.
                w_payout_nxt = payout_calc(r_result[11:8], r_result[7:4], r_result[3:0]);
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_stop1  = r_stop[2];
    assign o_stop2  = r_stop[1];
    assign o_stop3  = r_stop[0];
    assign o_debit  = r_debit;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_payout = r_payout;
    assign o_result = r_result;

endmodule

// File: tb/tb_reel_stop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reel_stop_sequencer
//
// Directed bench for reel_stop_sequencer with SPIN_CYCLES=8, STAGGER_CYCLES=4.
// Cycle 0 is the cycle in which START is first driven high; cycle N is the
// cycle after the N-th following rising clock edge. Outputs are sampled 1 ns
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_reel_stop_sequencer;

    localparam int SPIN = 8;
    localparam int STAG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        credit;
    logic        sreq;
    logic [3:0]  r1, r2, r3;
    logic        stop1, stop2, stop3;
    logic        debit, busy, done;
    logic [6:0]  payout;
    logic [11:0] result;

    reel_stop_sequencer #(
        .SPIN_CYCLES    (SPIN),
        .STAGGER_CYCLES (STAG),
        .CNT_W          (4),
        .PAYOUT_PAIR    (2),
        .PAYOUT_TRIPLE  (10),
        .PAYOUT_JACKPOT (50)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_credit_ok (credit),
        .i_stop_req  (sreq),
        .i_reel1     (r1),
        .i_reel2     (r2),
        .i_reel3     (r3),
        .o_stop1     (stop1),
        .o_stop2     (stop2),
        .o_stop3     (stop3),
        .o_debit     (debit),
        .o_busy      (busy),
        .o_done      (done),
        .o_payout    (payout),
        .o_result    (result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observations from the most recent run_spin call
    int          debit_first, debit_last, n_debit;
    int          done_first, n_done, busy_last;
    int          s1_rise, s2_rise, s3_rise;
    logic        all_stops_hi;
    logic [2:0]  rst_stops;
    logic        rst_busy, rst_done;
    logic [6:0]  rst_payout;
    logic [11:0] rst_result;

    // Raises START in cycle 0 and observes cycles 1..n.
    //   walk        : reels show (cycle mod 10) instead of a,b,c
    //   start_again : cycle in which START rises again (-1 = never)
    //   rst_at      : cycle in which RST is pulsed (-1 = never)
    //   q0..q2      : cycles with a one-cycle STOP_REQ pulse (-1 = none)
    task automatic run_spin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input bit walk, input int n, input int start_again,
                            input int rst_at, input int q0, input int q1, input int q2);
        logic p1, p2, p3;
        debit_first = -1; debit_last = -1; n_debit = 0;
        done_first = -1; n_done = 0; busy_last = -1;
        s1_rise = -1; s2_rise = -1; s3_rise = -1;
        all_stops_hi = 1'b1;
        rst_stops = 3'b000; rst_busy = 1'b1; rst_done = 1'b1;
        rst_payout = 7'h7f; rst_result = 12'hfff;
        if (walk) begin
            r1 = 4'd0; r2 = 4'd0; r3 = 4'd0;
        end else begin
            r1 = a; r2 = b; r3 = c;
        end
        p1 = stop1; p2 = stop2; p3 = stop3;
        start = 1'b1;
        for (int cyc = 1; cyc <= n; cyc++) begin
            tick();
            if (debit) begin
                n_debit++;
                if (debit_first < 0) debit_first = cyc;
                debit_last = cyc;
            end
            if (done) begin
                n_done++;
                if (done_first < 0) done_first = cyc;
            end
            if (busy) busy_last = cyc;
            if (!p1 && stop1 && s1_rise < 0) s1_rise = cyc;
            if (!p2 && stop2 && s2_rise < 0) s2_rise = cyc;
            if (!p3 && stop3 && s3_rise < 0) s3_rise = cyc;
            if (!(stop1 && stop2 && stop3)) all_stops_hi = 1'b0;
            p1 = stop1; p2 = stop2; p3 = stop3;

            if (walk) begin
                r1 = 4'(cyc % 10); r2 = 4'(cyc % 10); r3 = 4'(cyc % 10);
            end
            if (cyc == 2) start = 1'b0;
            if (cyc == start_again) start = 1'b1;
            sreq = (cyc == q0) || (cyc == q1) || (cyc == q2);
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                rst_stops  = {stop1, stop2, stop3};
                rst_busy   = busy;
                rst_done   = done;
                rst_payout = payout;
                rst_result = result;
                #1;
                rst = 1'b0;
                p1 = stop1; p2 = stop2; p3 = stop3;
            end
        end
        start = 1'b0;
        sreq  = 1'b0;
    endtask

    logic [11:0] vec_digits [6];
    logic [6:0]  vec_payout [6];
    int          held_debits;

    initial begin
        vec_digits[0] = 12'h333; vec_payout[0] = 7'd10;
        vec_digits[1] = 12'h353; vec_payout[1] = 7'd2;
        vec_digits[2] = 12'h123; vec_payout[2] = 7'd0;
        vec_digits[3] = 12'hAAA; vec_payout[3] = 7'd0;
        vec_digits[4] = 12'h773; vec_payout[4] = 7'd2;
        vec_digits[5] = 12'hAA3; vec_payout[5] = 7'd0;

        rst = 1'b1; start = 1'b0; credit = 1'b1; sreq = 1'b0;
        r1 = 4'd0; r2 = 4'd0; r3 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stops",  {29'd0, stop1, stop2, stop3}, 32'h7);
        check("reset_debit",  {31'd0, debit}, 32'd0);
        check("reset_busy",   {31'd0, busy},  32'd0);
        check("reset_done",   {31'd0, done},  32'd0);
        check("reset_payout", {25'd0, payout}, 32'd0);
        check("reset_result", {20'd0, result}, 32'd0);
        rst = 1'b0;
        tick();

        // Jackpot spin with full timing
        run_spin(4'd7, 4'd7, 4'd7, 1'b0, 20, -1, -1, -1, -1, -1);
        check("j_debit_cyc", debit_first, 1);
        check("j_debit_cnt", n_debit, 1);
        check("j_stop1_cyc", s1_rise, 9);
        check("j_stop2_cyc", s2_rise, 13);
        check("j_stop3_cyc", s3_rise, 17);
        check("j_done_cyc",  done_first, 18);
        check("j_done_cnt",  n_done, 1);
        check("j_busy_last", busy_last, 17);
        check("j_result",    {20'd0, result}, 32'h777);
        check("j_payout",    {25'd0, payout}, 32'd50);
        repeat (5) tick();
        check("j_payout_hold", {25'd0, payout}, 32'd50);

        // Digit patterns
        for (int i = 0; i < 6; i++) begin
            run_spin(vec_digits[i][11:8], vec_digits[i][7:4], vec_digits[i][3:0],
                     1'b0, 20, -1, -1, -1, -1, -1);
            check($sformatf("pat%0d_result", i), {20'd0, result}, {20'd0, vec_digits[i]});
            check($sformatf("pat%0d_payout", i), {25'd0, payout}, {25'd0, vec_payout[i]});
            repeat (2) tick();
        end

        // Reels change every cycle: capture instants are end of cycles 8/12/16
        run_spin(4'd0, 4'd0, 4'd0, 1'b1, 20, -1, -1, -1, -1, -1);
        check("walk_result", {20'd0, result}, 32'h826);
        check("walk_payout", {25'd0, payout}, 32'd0);
        repeat (2) tick();

        // No credit: request ignored
        credit = 1'b0;
        run_spin(4'd1, 4'd1, 4'd1, 1'b0, 20, -1, -1, -1, -1, -1);
        check("nocred_debit", n_debit, 0);
        check("nocred_stops", {31'd0, all_stops_hi}, 32'd1);
        check("nocred_done",  n_done, 0);
        credit = 1'b1;
        repeat (2) tick();

        // START held high across reset release
        start = 1'b1;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        held_debits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (debit) held_debits++;
        end
        check("held_start_debit", held_debits, 0);
        check("held_start_stop1", {31'd0, stop1}, 32'd1);
        start = 1'b0;
        repeat (2) tick();

        // Second START edge mid-spin is ignored
        run_spin(4'd3, 4'd5, 4'd3, 1'b0, 20, 5, -1, -1, -1, -1);
        check("midreq_debit_cnt", n_debit, 1);
        check("midreq_done_cyc",  done_first, 18);
        check("midreq_done_cnt",  n_done, 1);
        check("midreq_payout",    {25'd0, payout}, 32'd2);
        repeat (2) tick();

        // Request in the DONE cycle is accepted
        run_spin(4'd1, 4'd2, 4'd3, 1'b0, 22, 18, -1, -1, -1, -1);
        check("b2b_done_cyc",  done_first, 18);
        check("b2b_debit_cnt", n_debit, 2);
        check("b2b_debit2",    debit_last, 19);
        repeat (30) tick();

        // Reset pulsed mid-spin (reel 1 already captured)
        run_spin(4'd4, 4'd4, 4'd4, 1'b0, 20, -1, 11, -1, -1, -1);
        check("rst_stops",  {29'd0, rst_stops}, 32'h7);
        check("rst_busy",   {31'd0, rst_busy}, 32'd0);
        check("rst_done",   {31'd0, rst_done}, 32'd0);
        check("rst_payout", {25'd0, rst_payout}, 32'd0);
        check("rst_result", {20'd0, rst_result}, 32'd0);
        check("rst_no_done", n_done, 0);
        repeat (2) tick();

        // STOP_REQ pulses in cycles 3, 5, 7
        run_spin(4'd9, 4'd8, 4'd7, 1'b0, 20, -1, -1, 3, 5, 7);
`ifdef SKILL_STOP_EN
        check("skill_stop1", s1_rise, 4);
        check("skill_stop2", s2_rise, 6);
        check("skill_stop3", s3_rise, 8);
        check("skill_done",  done_first, 9);
`else
        check("skill_stop1", s1_rise, 9);
        check("skill_stop2", s2_rise, 13);
        check("skill_stop3", s3_rise, 17);
        check("skill_done",  done_first, 18);
`endif
        check("skill_result", {20'd0, result}, 32'h987);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reel_stop_sequencer.md
# reel_stop_sequencer

Controller that sequences one slot-machine spin: it accepts a start request when credit is available, releases the three reel counters, stops them one after another on a fixed stagger, captures the three stopped digits, and computes the payout. It sits between the coin/credit logic and the three reel counters, driving their STOP inputs, and reports DEBIT/PAYOUT back to the credit counter.

## Interface
- SPIN_CYCLES, 10000000, cycles all three reels spin before reel 1 stops (≥1)
- STAGGER_CYCLES, 5000000, cycles between successive reel stops (≥1)
- CNT_W, 24, phase counter width; must hold max(SPIN_CYCLES, STAGGER_CYCLES)-1
- PAYOUT_PAIR, 2, award when exactly two valid digits match
- PAYOUT_TRIPLE, 10, award when all three valid digits match (not 7-7-7)
- PAYOUT_JACKPOT, 50, award for 7-7-7; all payouts ≤99
- CLK  in  1  system clock; single clock domain
- RST  in  1  asynchronous, active-high reset
- START  in  1  spin request level; a rising edge is a request
- CREDIT_OK  in  1  credit counter nonzero
- STOP_REQ  in  1  player stop button (used only with SKILL_STOP_EN)
- REEL1, REEL2, REEL3  in  4 each  current BCD digit of each reel
- STOP1, STOP2, STOP3  out  1 each  1 = reel frozen
- DEBIT  out  1  one-cycle pulse when a spin is accepted
- BUSY  out  1  high from SPIN through EVAL
- DONE  out  1  one-cycle pulse, PAYOUT valid
- PAYOUT  out  7  award for last spin
- RESULT  out  12  captured digits {reel1, reel2, reel3}

## Operation
- All outputs registered. Reset values: STOP1..3=1, DEBIT=0, BUSY=0, DONE=0, PAYOUT=0, RESULT=0, state IDLE, counter 0. START edge register resets to 1, so START held high across reset release is not a request.
- States: IDLE, SPIN, STAG1, STAG2, EVAL.
- IDLE: request = START rising edge AND CREDIT_OK=1 → SPIN; STOP1..3←0, DEBIT←1 (one cycle), PAYOUT←0, counter←0. Rising edge with CREDIT_OK=0: ignored, no DEBIT.
- SPIN: SPIN_CYCLES cycles; on terminal count RESULT[11:8]←REEL1, STOP1←1, counter←0 → STAG1.
- STAG1: STAGGER_CYCLES cycles; on terminal count RESULT[7:4]←REEL2, STOP2←1 → STAG2.
- STAG2: STAGGER_CYCLES cycles; on terminal count RESULT[3:0]←REEL3, STOP3←1 → EVAL.
- EVAL: one cycle; PAYOUT←JACKPOT if all three =7; else TRIPLE if all equal; else PAIR if any two equal; else 0. Digit >9 never matches. DONE←1 → IDLE.
- START edges while BUSY are ignored (not queued); edge register keeps tracking so a held START never retriggers.
- PAYOUT/RESULT hold until the next accepted request.

## Timing
- Request sampled in cycle 0 → SPIN and DEBIT=1 in cycle 1.
- STOP1 rises in cycle 1+SPIN_CYCLES; STOP2 in +STAGGER_CYCLES; STOP3 another +STAGGER_CYCLES (same cycle as EVAL).
- DONE in cycle SPIN_CYCLES+2·STAGGER_CYCLES+2, coincident with IDLE; a request sampled in that cycle is accepted.
- RST asserted mid-spin: all outputs return to reset values immediately (reels freeze); no DONE, no PAYOUT.

## Configuration
- SKILL_STOP_EN defined: a STOP_REQ rising edge (edge register reset to 1) in SPIN, STAG1 or STAG2 acts as that phase's terminal count in that cycle; one edge ends one phase. In IDLE/EVAL ignored.
- Undefined: STOP_REQ ignored; phases are purely timed.

## Test plan
- SPIN_CYCLES=8, STAGGER_CYCLES=4, CREDIT_OK=1, START edge cycle 0 → DEBIT cycle 1, STOP1/2/3 rise cycles 9/13/17, DONE cycle 18.
- Reels frozen at 7,7,7 → RESULT=0x777, PAYOUT=50; 3,3,3 → 10; 3,5,3 → 2; 1,2,3 → 0; A,A,A (invalid) → 0.
- START edge with CREDIT_OK=0 → no DEBIT, STOP1..3 stay 1; START held high across reset release → no spin.
- Second START edge in cycle 5 of a spin → ignored, exactly one DEBIT, DONE cycle 18; START edge in cycle 18 → accepted, DEBIT cycle 19.
- RST pulsed in cycle 11 → STOP1..3=1, BUSY=0, PAYOUT=0 immediately, no DONE.
- With SKILL_STOP_EN, STOP_REQ edges at cycles 3, 5, 7 → STOP1/2/3 rise cycles 4/6/8, DONE cycle 9.
